// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: picks predicted, sequential or recovery PC and carries
// pc/hit/valid through IF->ID->EX for predictor training and redirect control.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             stall_id_i,
    input  logic             hit_i,
    input  logic [31:0]      predicted_pc_i,
    input  logic [1:0]       wrong_predicted_i,
    input  logic [31:0]      alu_pc_i,
    input  logic             is_ctrl_ex_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_ex_o,
    output logic             hit_ex_o,
    output logic             valid_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic {RUN, PENDING} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        valid;
    } stage_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    stage_t           id_q, id_d;
    stage_t           ex_q, ex_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic        run;
    logic        mispred;
    logic [31:0] tgt;
    logic        redirect;
    logic        bubble;
    logic        br_inc;
    logic        mis_inc;

    assign run     = (state_q == RUN);
    assign mispred = ex_q.valid & (wrong_predicted_i != 2'b00);
    assign tgt     = (wrong_predicted_i == 2'b01) ? ex_q.pc + 32'd4
                                                  : alu_pc_i;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mispred && stall_i) state_d = PENDING;
            PENDING: if (!stall_i)           state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // outputs of the FSM
    always_comb begin
        redirect = 1'b0;
        bubble   = 1'b0;
        unique case (state_q)
            RUN: begin
                redirect = mispred & ~stall_i;
                bubble   = ~mispred & ~stall_i & stall_id_i;
            end
            PENDING: redirect = ~stall_i;
            default: redirect = 1'b0;
        endcase
    end

    assign br_inc  = run & ~stall_i & ex_q.valid & is_ctrl_ex_i;
    assign mis_inc = run & mispred;

    // pipeline next values; a redirect overrides both hazard kinds
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        id_d   = id_q;
        ex_d   = ex_q;
        if (redirect) begin
            pc_d = run ? tgt : pend_q;
            id_d = '0;
            ex_d = '0;
        end else if (!stall_i) begin
            if (stall_id_i) begin
                ex_d = '0;
            end else begin
                pc_d = hit_i ? predicted_pc_i : pc_q + 32'd4;
                id_d = '{pc: pc_q, hit: hit_i, valid: 1'b1};
                ex_d = id_q;
            end
        end
        if (run && mispred && stall_i) pend_d = tgt;
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (br_inc && !(&branch_cnt_q))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (mis_inc && !(&mispredict_cnt_q))
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q             <= RESET_PC;
            pend_q           <= '0;
            id_q             <= '0;
            ex_q             <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            pc_q             <= pc_d;
            pend_q           <= pend_d;
            id_q             <= id_d;
            ex_q             <= ex_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // bubbles present zeros so they never train the predictor
    assign pc_o             = pc_q;
    assign valid_ex_o       = ex_q.valid;
    assign pc_ex_o          = ex_q.valid ? ex_q.pc : 32'd0;
    assign hit_ex_o         = ex_q.valid & ex_q.hit;
    assign redirect_o       = redirect;
    assign flush_if_id_o    = redirect;
    assign flush_id_ex_o    = redirect | bubble;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
